// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 memory completer.
package apb4_pkg;

  // Transfer FSM: IDLE waits for a setup phase, ACCESS counts wait states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Largest wait-state count the 4-bit counter can hold.
  localparam int MAX_WAIT_STATES = 15;

  // PSLVERR encodings.
  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  // Byte-strobe width for a given data width.
  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb4_mem_array.sv
// Word-organised storage: byte-enable synchronous write, combinational read.
module apb4_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int SW        = DATA_WIDTH / 8,
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic                  i_we,
  input  logic [SW-1:0]         i_be,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Byte-lane write; lanes without a strobe keep their old contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 completer in front of a word memory: byte strobes, programmable wait
// states, PSLVERR on misaligned/out-of-range addresses, abort on PSEL drop.
module apb4_mem_slave
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int SW    = strb_width(DATA_WIDTH);
  localparam int LSB   = $clog2(SW);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(MAX_WAIT_STATES + 1);
  localparam int WS    = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;

  localparam logic [CNT_W-1:0]      WS_INIT    = CNT_W'(WS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_A    = (ADDR_WIDTH + 1)'(DEPTH);

  apb_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata_nxt;

  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_misalign, w_oor, w_err, w_setup, w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Address decode works on the live bus; err/read data are latched at setup.
  assign w_word     = paddr >> LSB;
  assign w_idx      = paddr[LSB +: IDX_W];
  assign w_misalign = |(paddr & ALIGN_MASK);
  assign w_oor      = {1'b0, w_word} >= DEPTH_A;
  assign w_err      = w_misalign | w_oor;
  assign w_setup    = psel & ~penable;

  assign pready  = (r_state == ST_ACCESS) && (r_cnt == '0) && psel && penable;
  assign pslverr = (pready && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign prdata  = r_prdata;

  // Writes commit on the completing cycle using the live address and data.
  assign w_we = pready & pwrite & ~r_err;

  apb4_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_idx   (w_idx),
    .i_we    (w_we),
    .i_be    (pstrb),
    .i_wdata (pwdata),
    .o_rdata (w_rdata)
  );

  // State, wait counter, captured error and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_prdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
      r_prdata <= w_prdata_nxt;
    end
  end

  // Next state: a setup phase restarts a transfer from any state; in ACCESS
  // a dropped PSEL aborts, otherwise count down wait states then complete.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = r_err;
    w_prdata_nxt = r_prdata;
    if (w_setup) begin
      w_state_nxt = ST_ACCESS;
      w_cnt_nxt   = WS_INIT;
      w_err_nxt   = w_err;
      if (!pwrite) w_prdata_nxt = w_err ? '0 : w_rdata;
    end else if (r_state == ST_ACCESS) begin
      if (!psel) begin
        w_state_nxt = ST_IDLE;
      end else if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Randomised APB4 traffic against two instances (0 and 3 wait states),
// checked against an array-based model of the memory and response rules.
module tb_apb4_mem_slave;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]        paddr   = '0;
  logic [1:0]           psel    = '0;
  logic                 penable = 1'b0;
  logic                 pwrite  = 1'b0;
  logic [DW-1:0]        pwdata  = '0;
  logic [SW-1:0]        pstrb   = '0;
  logic [1:0][DW-1:0]   prdata;
  logic [1:0]           pready;
  logic [1:0]           pslverr;

  apb4_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb4_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  // Reference model: memory image and last captured read data per instance.
  logic [DW-1:0] m_mem [2][DEPTH];
  logic [DW-1:0] m_rd  [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit m_err(input logic [AW-1:0] a);
    return (a % SW != 0) || ((int'(a) / SW) >= DEPTH);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [SW-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;
  endtask

  // One APB transfer on instance d. abort_at>0 drops PSEL after that many
  // access cycles. Returns right after the completing cycle is sampled, so a
  // following call produces a back-to-back setup.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [SW-1:0] st, input int abort_at);
    bit e;
    bit done;
    int n;
    e = m_err(a);
    @(posedge clk); #1;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;
    @(negedge clk);
    chk("setup_rdy", 64'(pready[d]), 64'(0));
    if (!wr) m_rd[d] = e ? '0 : m_mem[d][int'(a) / SW];
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      chk("rdata", 64'(prdata[d]), 64'(m_rd[d]));
      if (abort_at == n) begin
        chk("abort_rdy", 64'(pready[d]), 64'(0));
        @(posedge clk); #1;
        psel    = '0;
        penable = 1'b0;
        @(negedge clk);
        chk("abort_idle", 64'(pready[d]), 64'(0));
        done = 1;
      end else if (pready[d]) begin
        chk("acc_cycles", 64'(n), 64'(ws(d) + 1));
        chk("slverr", 64'(pslverr[d]), 64'(e));
        if (wr && !e) m_mem[d][int'(a) / SW] = merge(m_mem[d][int'(a) / SW], wd, st);
        done = 1;
      end else begin
        chk("slverr_lo", 64'(pslverr[d]), 64'(0));
        if (n > 20) begin
          chk("timeout", 64'(1), 64'(0));
          @(posedge clk); #1;
          psel    = '0;
          penable = 1'b0;
          done = 1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, r, ab, ai;
    bit wr;
    logic [AW-1:0] a;

    // Reset values
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_pready", 64'(pready[i]), 64'(0));
      chk("rst_pslverr", 64'(pslverr[i]), 64'(0));
      chk("rst_prdata", 64'(prdata[i]), 64'(0));
      m_rd[i] = '0;
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Fill both memories so every later read has a known value
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < DEPTH; w++)
        xfer(i, 1'b1, AW'(w * SW), $urandom, 4'hF, 0);
    idle();

    // Full write then back-to-back read, 0 wait states
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0);
    xfer(0, 1'b0, 12'h010, '0, 4'h0, 0);
    chk("tp1_rd", 64'(prdata[0]), 64'(32'hDEADBEEF));
    // Partial strobe write; read with nonzero strobes
    xfer(0, 1'b1, 12'h010, 32'h11223344, 4'b0101, 0);
    xfer(0, 1'b0, 12'h010, '0, 4'hF, 0);
    chk("tp2_rd", 64'(prdata[0]), 64'(32'hDE22BE44));
    idle();

    // Wait-state read
    xfer(1, 1'b0, 12'h020, '0, 4'h0, 0);
    idle();

    // Out-of-range read, misaligned write, then readback
    xfer(0, 1'b0, 12'h400, '0, 4'h0, 0);
    chk("tp4_oor_rd", 64'(prdata[0]), 64'(0));
    xfer(0, 1'b1, 12'h012, 32'hFFFFFFFF, 4'hF, 0);
    xfer(0, 1'b0, 12'h010, '0, 4'h0, 0);
    chk("tp4_unchanged", 64'(prdata[0]), 64'(32'hDE22BE44));
    idle();

    // Abort after one access cycle, then readback
    xfer(1, 1'b1, 12'h030, 32'h12345678, 4'hF, 1);
    xfer(1, 1'b0, 12'h030, '0, 4'h0, 0);
    idle();

    // Reset during an access cycle of a write
    @(posedge clk); #1;
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030;
    pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("rst_acc_rdy", 64'(pready[1]), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst_mid_rdy", 64'(pready[1]), 64'(0));
    chk("rst_mid_err", 64'(pslverr[1]), 64'(0));
    chk("rst_mid_rd", 64'(prdata[1]), 64'(0));
    m_rd[0] = '0;
    m_rd[1] = '0;
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    rst = 1'b1;
    xfer(1, 1'b0, 12'h030, '0, 4'h0, 0);
    idle();

    // Back-to-back write/read on the wait-state instance
    xfer(1, 1'b1, 12'h040, 32'hA5A5A5A5, 4'hF, 0);
    xfer(1, 1'b0, 12'h040, '0, 4'h0, 0);
    chk("tp6_rd", 64'(prdata[1]), 64'(32'hA5A5A5A5));

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      ai = int'($urandom_range(0, DEPTH - 1)) * SW;
      if (r < 7)       a = AW'(ai);
      else if (r == 7) a = AW'(ai + int'($urandom_range(1, SW - 1)));
      else             a = AW'($urandom_range(1024, 4095));
      ab = 0;
      if (ws(d) > 0 && $urandom_range(0, 9) == 0) ab = int'($urandom_range(1, ws(d)));
      xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), ab);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
